// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the eight-digit seven-segment scan driver:
// digit count, blank patterns and the active-low hex glyph table {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // 0-9, A, b, C, d, E, F (a lit segment is a 0)
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side load bus and board-side display pins of the seven-segment scan driver.
interface seg7_scan_driver_if;

  logic [31:0] data;
  logic [7:0]  dots;
  logic [7:0]  digit_en;
  logic        load;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output data, dots, digit_en, load,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  data, dots, digit_en, load,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with frame-aligned value updates.
// Optional SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero digits (digit 0 and dotted digits stay lit).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_stg_data, r_shd_data;
  logic [7:0]       r_stg_dots, r_shd_dots;
  logic [7:0]       r_stg_en,   r_shd_en;
  logic             r_pending;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_done;

  logic             w_cnt_last;
  logic             w_boundary;
  logic [3:0]       w_nibble;
  logic [6:0]       w_glyph;
  logic             w_lz_blank;
  logic             w_blank;

  assign w_cnt_last = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_boundary = w_cnt_last && (r_idx == IDX_W'(DIGITS - 1));
  assign w_nibble   = r_shd_data[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_upper_zero;

  // NOTE: every bit gets a default before the loop so no latch can be inferred.
  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < DIGITS; i++)
      w_upper_zero[i] = ((r_shd_data >> (4 * i)) == 32'h0);
  end

  assign w_lz_blank = (r_idx != '0) && w_upper_zero[r_idx] && !r_shd_dots[r_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_blank = (32'(r_cnt) < BLANK_CYCLES) || !r_shd_en[r_idx] || w_lz_blank;

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // NOTE: all state uses <= so every register samples pre-edge values; the boundary
  // transfer therefore takes the old staging even when load fires in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      // NOTE: staging and shadow are reset as well, so the display stays dark until
      // a first load has crossed a frame boundary.
      r_stg_data   <= '0;
      r_stg_dots   <= '0;
      r_stg_en     <= '0;
      r_shd_data   <= '0;
      r_shd_dots   <= '0;
      r_shd_en     <= '0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (w_cnt_last)
        r_idx <= r_idx + 1'b1;

      if (bus.load) begin
        r_stg_data <= bus.data;
        r_stg_dots <= bus.dots;
        r_stg_en   <= bus.digit_en;
      end

      if (bus.load)
        r_pending <= 1'b1;
      else if (w_boundary)
        r_pending <= 1'b0;

      if (w_boundary && r_pending) begin
        r_shd_data <= r_stg_data;
        r_shd_dots <= r_stg_dots;
        r_shd_en   <= r_stg_en;
      end

      r_frame_done <= w_boundary;

      if (w_blank) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(8'b1 << r_idx);
        r_seg <= w_glyph;
        r_dp  <= ~r_shd_dots[r_idx];
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-indexed reference model predicts every
// output sample from the list of loads and the frame arithmetic; a monitor compares.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;
  localparam int FRAME    = 8 * SCAN_DIV;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [7:0]  dots;
    logic [7:0]  en;
  } load_t;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  load_t loads [$];
  obs_t  exp_q [$];
  int    t      = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_on = 1'b0;

  // Lit segments of each hex glyph, written as segment letters.
  string GLYPH_LIT [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic logic [6:0] glyph(input logic [3:0] n);
    string      lit;
    logic [6:0] g;
    lit = GLYPH_LIT[n];
    g   = 7'h7F;
    for (int k = 0; k < lit.len(); k++)
      g[int'(lit[k]) - 97] = 1'b0;
    return g;
  endfunction

  function automatic obs_t dark_obs();
    obs_t o;
    o.an  = 8'hFF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.fd  = 1'b0;
    return o;
  endfunction

  // Output expected one cycle after cycle tc (tc counted from reset release).
  function automatic obs_t model(input int tc);
    obs_t        o;
    int          slot_pos, digit, frame, msd;
    logic [31:0] d;
    logic [7:0]  dt, en;
    logic [3:0]  nib;
    bit          lit;
    slot_pos = tc % SCAN_DIV;
    digit    = (tc / SCAN_DIV) % 8;
    frame    = tc / FRAME;
    d = '0; dt = '0; en = '0;
    // A frame shows the last load strictly before the previous frame's final cycle.
    if (frame > 0)
      foreach (loads[k])
        if (loads[k].cyc <= frame * FRAME - 2) begin
          d  = loads[k].data;
          dt = loads[k].dots;
          en = loads[k].en;
        end
    o    = dark_obs();
    o.fd = (tc % FRAME) == FRAME - 1;
    lit  = (slot_pos >= BLANK) && en[digit];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 0; i < 8; i++)
      if (((d >> (4 * i)) & 32'hF) != 0) msd = i;
    if (digit > msd && !dt[digit]) lit = 1'b0;
`else
    msd = 0;
`endif
    if (lit) begin
      nib   = 4'((d >> (4 * digit)) & 32'hF);
      o.an  = 8'hFF ^ (8'd1 << digit);
      o.seg = glyph(nib);
      o.dp  = !dt[digit];
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected sample per cycle, compared mid-cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("an",         32'(bus.an),         32'(e.an));
          check("seg",        32'(bus.seg),        32'(e.seg));
          check("dp",         32'(bus.dp),         32'(e.dp));
          check("frame_done", 32'(bus.frame_done), 32'(e.fd));
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1.
  task automatic tick(input bit ld, input logic [31:0] d, input logic [7:0] dt, input logic [7:0] en);
    load_t l;
    bus.load     = ld;
    bus.data     = ld ? d  : $urandom();
    bus.dots     = ld ? dt : 8'($urandom());
    bus.digit_en = ld ? en : 8'($urandom());
    if (ld) begin
      l.cyc = t; l.data = d; l.dots = dt; l.en = en;
      loads.push_back(l);
    end
    exp_q.push_back(model(t));
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, '0, '0);
  endtask

  task automatic to_boundary();
    while ((t % FRAME) != FRAME - 1) idle(1);
  endtask

  task automatic do_reset(input bit with_load);
    rst          = 1'b1;
    bus.load     = with_load;
    bus.data     = 32'h7777_7777;
    bus.dots     = 8'hFF;
    bus.digit_en = 8'hFF;
    exp_q.push_back(dark_obs());
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.load = 1'b0;
    loads.delete();
    t = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  ren, rdt;
    bus.load = 1'b0; bus.data = '0; bus.dots = '0; bus.digit_en = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(dark_obs());
    mon_on = 1'b1;
    do_reset(1'b0);

    // Dark after reset, frame_done every frame.
    idle(40);

    // Basic word, all digits enabled.
    tick(1'b1, 32'h1234_ABCD, 8'h00, 8'hFF);
    idle(80);

    // Pending 9 overtaken by a load in the boundary cycle.
    tick(1'b1, 32'h0000_0009, 8'h00, 8'hFF);
    to_boundary();
    tick(1'b1, 32'h0000_0005, 8'h00, 8'hFF);
    idle(70);

    // Leading zeros with a dot on digit 4.
    tick(1'b1, 32'h0000_00F0, 8'h10, 8'hFF);
    idle(70);

    // Back-to-back loads: last one wins; partial enable mask.
    tick(1'b1, 32'hAAAA_AAAA, 8'hFF, 8'hFF);
    tick(1'b1, 32'hBBBB_BBBB, 8'h00, 8'hFF);
    tick(1'b1, 32'h0F1E_2D3C, 8'hA5, 8'h5A);
    idle(70);

    // Reset mid-slot with data pending; rst and load together.
    to_boundary();
    idle(6);
    tick(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
    idle(2);
    do_reset(1'b1);
    idle(70);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        rd  = $urandom();
        rd  = rd >> (4 * $urandom_range(0, 8));
        ren = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'hFF;
        rdt = ($urandom_range(0, 1) == 0) ? 8'($urandom()) : 8'h00;
        tick(1'b1, rd, rdt, ren);
      end else begin
        idle(1);
      end
    end

    @(negedge clk);
    #1;
    mon_on = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
